// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among N_REQ valid/ready requesters.
// One transfer in flight at a time; an optional wait-state timeout aborts hung slaves.
module apb_rr_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*32-1:0]  req_addr,
   input  logic [N_REQ-1:0]     req_write,
   input  logic [N_REQ*32-1:0]  req_wdata,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic [31:0]          paddr,
   output logic                 pwrite,
   output logic                 psel,
   output logic                 penable,
   output logic [31:0]          pwdata,
   input  logic [31:0]          prdata,
   input  logic                 pready
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StAccess = 2'd2;
   localparam logic [1:0] StResp   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0] grant_q, grant_d;
   logic [31:0]     addr_q, addr_d;
   logic            write_q, write_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   logic            win_found;
   logic [PtrW-1:0] win_idx;
   logic [PtrW-1:0] scan_idx;
   int unsigned     scan_pos;
   logic [31:0]     addr_sel;
   logic [31:0]     wdata_sel;
   logic [CntW-1:0] cnt_inc;

   // Scan starting at rr_ptr and wrap modulo N_REQ; first valid requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_pos  = 0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_pos = (32'(rr_ptr_q) + i) % N_REQ;
         scan_idx = PtrW'(scan_pos);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx == PtrW'(i)) begin
            addr_sel  = req_addr[32*i +: 32];
            wdata_sel = req_wdata[32*i +: 32];
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (win_found) begin
               grant_d = win_idx;
               addr_d  = addr_sel;
               write_d = req_write[win_idx];
               wdata_d = wdata_sel;
               state_d = StSetup;
            end
         end
         StSetup: state_d = StAccess;
         StAccess: begin
            cnt_d = cnt_inc;
            // pready takes priority over a timeout landing in the same cycle.
            if (pready) begin
               rdata_d = write_q ? 32'h0 : prdata;
               err_d   = 1'b0;
               state_d = StResp;
            end else if ((TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT)) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         default: begin
            rr_ptr_d = (grant_q == PtrW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            cnt_d    = '0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   logic active;
   logic in_resp;

   assign active  = (state_q != StIdle);
   assign in_resp = (state_q == StResp);

   assign psel      = (state_q == StSetup) || (state_q == StAccess);
   assign penable   = (state_q == StAccess);
   assign paddr     = active ? addr_q : 32'h0;
   assign pwrite    = active ? write_q : 1'b0;
   assign pwdata    = active ? wdata_q : 32'h0;
   assign rsp_rdata = in_resp ? rdata_q : 32'h0;
   assign rsp_err   = in_resp ? err_q : 1'b0;

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_ready[i] = rst_n && (state_q == StIdle) && win_found && (win_idx == PtrW'(i));
         rsp_valid[i] = in_resp && (grant_q == PtrW'(i));
      end
   end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: N_REQ=2, TIMEOUT=16, with a small APB RAM slave model.
module tb_apb_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_addr;
   logic [1:0]  req_write;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] paddr;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   logic [31:0] mem [16];
   int n_assert = 0;
   int n_fail   = 0;

   apb_rr_arbiter #(
      .N_REQ   (2),
      .TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Garbage on prdata outside the pready cycle exposes early capture.
   assign prdata = pready ? mem[paddr[5:2]] : 32'hBAD0BAD0;

   always @(posedge clk) begin
      if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_addr  = 64'h0;
      req_write = 2'b00;
      req_wdata = 64'h0;
      pready    = 1'b1;
      #3;
      chk("rst_psel", 32'(psel), 32'h0);
      chk("rst_penable", 32'(penable), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Write then read back through requester 0, zero wait states.
      step();
      req_valid       = 2'b01;
      req_addr[31:0]  = 32'h10;
      req_write       = 2'b01;
      req_wdata[31:0] = 32'hDEADBEEF;
      settle();
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_idle_psel", 32'(psel), 32'h0);
      step();
      req_valid      = 2'b00;
      req_addr[31:0] = 32'hFFFFFFFF;
      settle();
      chk("t1_setup_psel", 32'(psel), 32'h1);
      chk("t1_setup_penable", 32'(penable), 32'h0);
      chk("t1_setup_paddr", paddr, 32'h10);
      chk("t1_setup_pwrite", 32'(pwrite), 32'h1);
      chk("t1_setup_pwdata", pwdata, 32'hDEADBEEF);
      step();
      settle();
      chk("t1_access_penable", 32'(penable), 32'h1);
      chk("t1_access_rsp", 32'(rsp_valid), 32'h0);
      step();
      settle();
      chk("t1_wr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_wr_rsp_err", 32'(rsp_err), 32'h0);
      chk("t1_wr_rsp_rdata", rsp_rdata, 32'h0);
      chk("t1_resp_psel", 32'(psel), 32'h0);
      step();
      req_valid      = 2'b01;
      req_addr[31:0] = 32'h10;
      req_write      = 2'b00;
      settle();
      chk("t1_idle_paddr", paddr, 32'h0);
      chk("t1_rd_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      settle();
      chk("t1_rd_pwrite", 32'(pwrite), 32'h0);
      step();
      step();
      settle();
      chk("t1_rd_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rd_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("t1_rd_err", 32'(rsp_err), 32'h0);

      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // Both requesters valid continuously: grants alternate 0,1,0,1.
      for (int k = 0; k < 4; k++) begin
         step();
         req_valid = 2'b11;
         req_addr  = {32'h24, 32'h20};
         req_write = 2'b00;
         settle();
         chk("t2_ready", 32'(req_ready), 32'(1 << (k % 2)));
         step();
         settle();
         chk("t2_paddr", paddr, (k % 2 == 1) ? 32'h24 : 32'h20);
         step();
         step();
         settle();
         chk("t2_rsp_valid", 32'(rsp_valid), 32'(1 << (k % 2)));
      end

      // Three wait states on a read.
      step();
      req_valid      = 2'b01;
      req_addr[31:0] = 32'h10;
      settle();
      chk("t3_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      pready    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         settle();
         chk("t3_wait_penable", 32'(penable), 32'h1);
         chk("t3_wait_paddr", paddr, 32'h10);
         chk("t3_wait_rsp", 32'(rsp_valid), 32'h0);
      end
      step();
      pready = 1'b1;
      settle();
      chk("t3_ready_psel", 32'(psel), 32'h1);
      step();
      settle();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_rdata", rsp_rdata, 32'hDEADBEEF);

      // Timeout on requester 1, then a normal transfer on requester 0.
      step();
      req_valid       = 2'b10;
      req_addr[63:32] = 32'h10;
      pready          = 1'b0;
      settle();
      chk("t4_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 2'b00;
      for (int i = 0; i < 16; i++) begin
         step();
         settle();
         chk("t4_access_penable", 32'(penable), 32'h1);
         chk("t4_access_rsp", 32'(rsp_valid), 32'h0);
      end
      step();
      settle();
      chk("t4_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t4_rsp_err", 32'(rsp_err), 32'h1);
      chk("t4_rsp_rdata", rsp_rdata, 32'h0);
      chk("t4_resp_psel", 32'(psel), 32'h0);
      step();
      pready    = 1'b1;
      req_valid = 2'b01;
      settle();
      chk("t4_idle_psel", 32'(psel), 32'h0);
      chk("t4_next_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      step();
      step();
      settle();
      chk("t4_next_rsp", 32'(rsp_valid), 32'h1);
      chk("t4_next_err", 32'(rsp_err), 32'h0);
      chk("t4_next_rdata", rsp_rdata, 32'hDEADBEEF);

      // pready rises on the 16th ACCESS cycle: normal completion wins.
      step();
      req_valid = 2'b01;
      pready    = 1'b0;
      settle();
      chk("t5_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      for (int i = 0; i < 15; i++) begin
         step();
      end
      step();
      pready = 1'b1;
      settle();
      chk("t5_last_rsp", 32'(rsp_valid), 32'h0);
      step();
      settle();
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t5_rsp_err", 32'(rsp_err), 32'h0);
      chk("t5_rdata", rsp_rdata, 32'hDEADBEEF);

      // Reset during ACCESS with both requesters pending; rr_ptr is 1 beforehand.
      step();
      req_valid = 2'b11;
      settle();
      chk("t6_ready_pre", 32'(req_ready), 32'h2);
      step();
      pready = 1'b0;
      step();
      settle();
      chk("t6_access_penable", 32'(penable), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_psel", 32'(psel), 32'h0);
      chk("t6_rst_penable", 32'(penable), 32'h0);
      chk("t6_rst_rsp", 32'(rsp_valid), 32'h0);
      step();
      step();
      #1 rst_n = 1'b1;
      pready = 1'b1;
      settle();
      chk("t6_post_ready", 32'(req_ready), 32'h1);
      chk("t6_post_rsp", 32'(rsp_valid), 32'h0);
      step();
      req_valid = 2'b00;
      settle();
      chk("t6_setup_rsp", 32'(rsp_valid), 32'h0);
      step();
      step();
      settle();
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
